// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, instruction-bus initiator, IF/ID register
// Handles redirects, stalls, bus access faults and misaligned branch targets.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        trap_en,
  input  logic [31:0] trap_target,
  output logic        ibus_rd_en,
  output logic [31:0] ibus_addr,
  input  logic [31:0] ibus_rd_data,
  input  logic        ibus_fault,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        inst_access_fault,
  output logic        inst_misaligned,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        acc_fault_q, acc_fault_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] trap_pc;

  assign trap_pc = {trap_target[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      inst_q       <= NOP_INST;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      acc_fault_q  <= 1'b0;
      misaligned_q <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      acc_fault_q  <= acc_fault_d;
      misaligned_q <= misaligned_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    acc_fault_d  = acc_fault_q;
    misaligned_d = misaligned_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (trap_en) pc_d = trap_pc;
      end
      FETCH: begin
        if (trap_en) begin
          pc_d         = trap_pc;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
        end else if (br_en && br_target[1:0] == 2'b00) begin
          // The word on the bus this cycle is wrong-path and is dropped.
          pc_d         = br_target;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
        end else if (br_en) begin
          misaligned_d = 1'b1;
          fault_addr_d = br_target;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          state_d      = FAULT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (ibus_fault) begin
          acc_fault_d  = 1'b1;
          fault_addr_d = pc_q;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          state_d      = FAULT;
        end else begin
          inst_d       = ibus_rd_data;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
        end
      end
      FAULT: begin
        inst_valid_d = 1'b0;
        // Only a trap leaves FAULT; fault_addr is kept for mtval.
        if (trap_en) begin
          acc_fault_d  = 1'b0;
          misaligned_d = 1'b0;
          pc_d         = trap_pc;
          state_d      = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign ibus_addr         = pc_q;
  assign ibus_rd_en        = (state_q == FETCH) & ~stall & ~br_en & ~trap_en;
  assign inst              = inst_q;
  assign inst_pc           = inst_pc_q;
  assign inst_valid        = inst_valid_q;
  assign inst_access_fault = acc_fault_q;
  assign inst_misaligned   = misaligned_q;
  assign fault_addr        = fault_addr_q;

endmodule
